kvosic_counter_ctrl: RTL
========================

// Module: kvosic_counter_ctrl
// PURPOSE
//  Command-driven sequencer for the kvosic 4-bit counter datapath: accepts opcodes over a valid/ready port and
//  drives the counter's step/direction/load controls. Supports free run, run-to-target, single step and load,
//  with a programmable prescaler. Sits between the tt_um top-level pins (ui_in) and the counter register.
// PARAMETERS
//  WIDTH          4   counter width; cmd_arg, cnt_value, cnt_load_val widths
//  PRESC_W        4   prescaler register width
//  PRESC_DEFAULT  0   prescaler reload value after reset (step every PRESC+1 cycles)
// PORTS
//  clk           in   1        clock; all state on rising edge
//  rst_n         in   1        reset, synchronous, active-low
//  ena           in   1        design selected; 0 freezes all state
//  cmd_valid     in   1        command offered
//  cmd_ready     out  1        command accepted when cmd_valid & cmd_ready
//  cmd_op        in   3        opcode
//  cmd_arg       in   WIDTH    opcode argument
//  cnt_value     in   WIDTH    current counter value (returned from counter)
//  cnt_en        out  1        step counter by one this cycle
//  cnt_up        out  1        direction: 1 = up, 0 = down
//  cnt_load      out  1        load cnt_load_val this cycle (one-cycle pulse)
//  cnt_load_val  out  WIDTH    load value
//  busy          out  1        state != IDLE
//  done          out  1        one-cycle pulse: RUN_TO reached target
// BEHAVIOUR
//  - Opcodes: 0 NOP, 1 LOAD arg, 2 RUN (dir = arg[0]), 3 STOP, 4 SET_PRESC arg[PRESC_W-1:0],
//    5 RUN_TO target = arg (current cnt_up), 6 STEP (dir = arg[0]), 7 reserved -> NOP. No error flag.
//  - States: IDLE, RUN, RUN_TO, LOAD, STEP. All outputs reset to 0 except cnt_up = 1. State resets to IDLE;
//    prescaler counter resets to 0; prescaler reload resets to PRESC_DEFAULT.
//  - cmd_ready = ena & rst_n & state not in {LOAD, STEP}. Commands accepted in RUN/RUN_TO pre-empt the run.
//  - LOAD: next cycle state LOAD, cnt_load = 1, cnt_load_val = arg, cnt_en = 0; following cycle -> IDLE.
//    Any run is stopped. cnt_load_val holds its value until the next LOAD.
//  - RUN: cnt_up <= arg[0], prescaler cleared; cnt_en = 1 each cycle prescaler count == reload,
//    i.e. first step on cycle reload+1 after accept, then every reload+1 cycles. Counter wraps mod 2^WIDTH.
//  - STOP: -> IDLE next cycle; no further cnt_en. STOP in IDLE is a NOP.
//  - SET_PRESC: updates reload in any accepting state; running state and prescaler count unchanged;
//    new reload takes effect at the next compare. Prescaler count saturates/clears when it exceeds reload.
//  - RUN_TO: compare cnt_value == target every cycle in RUN_TO. On match: cnt_en = 0 that cycle, -> IDLE,
//    done = 1 next cycle for exactly one cycle. Target equal on entry -> zero steps, done one cycle after match.
//    Wraps through 2^WIDTH boundary; at most 2^WIDTH - 1 steps.
//  - STEP: cnt_up <= arg[0]; next cycle state STEP, cnt_en = 1 for exactly one cycle; then IDLE.
//  - cnt_en, cnt_load are decoded from registered state; cnt_en also depends combinationally on cnt_value
//    (RUN_TO match) and the prescaler compare; no other combinational input-to-output paths besides cmd_ready.
//  - cnt_en and cnt_load are never high in the same cycle.
//  - ena = 0: state, prescaler, registers hold; cnt_en = cnt_load = done = 0; cmd_ready = 0. Resume exactly.
//  - Reset mid-operation: next cycle IDLE, all outputs at reset values, no done pulse, reload = PRESC_DEFAULT.
// STRUCTURE
//  - Package kvosic_ctrl_pkg: opcode localparams (OP_NOP..OP_STEP), state encoding, PRESC_DEFAULT.
//  - Sub-module kvosic_prescaler: reload reg input, clear, enable -> tick; instantiated once.
//  - FSM + command decode in this module; counter register remains separate, instantiated by tt_um top.
// TESTING
//  - Reset: rst_n = 0 for 3 clocks, cmd_valid = 1 -> cmd_ready = 0, cnt_en = 0, cnt_up = 1, done = 0, busy = 0.
//  - LOAD 4'hA -> cnt_load high exactly 1 cycle, cnt_load_val = 4'hA, cmd_ready low that cycle; cnt_value = 4'hA.
//  - SET_PRESC 2, RUN up, STOP after 9 cycles -> cnt_en every 3rd cycle, exactly 3 steps, value +3.
//  - LOAD 4'hE, RUN_TO 4'h2 (up, presc 0) -> steps E,F,0,1,2 (4 cnt_en), done 1 cycle, busy falls.
//  - RUN_TO target == cnt_value -> zero cnt_en, done pulse 1 cycle; STEP dir 0 from 4'h0 -> 4'hF.
//  - RUN, ena = 0 for 5 cycles -> no cnt_en, prescaler frozen; rst_n = 0 mid RUN_TO -> IDLE, no done.

Source files
------------

// File: rtl/kvosic_ctrl_pkg.sv
// Shared opcode and state encodings for the kvosic counter sequencer.
package kvosic_ctrl_pkg;
  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_STOP      = 3'd3;
  localparam logic [2:0] OP_SET_PRESC = 3'd4;
  localparam logic [2:0] OP_RUN_TO    = 3'd5;
  localparam logic [2:0] OP_STEP      = 3'd6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_RUN_TO = 3'd2;
  localparam logic [2:0] ST_LOAD   = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;

  localparam int PRESC_DEFAULT = 0;
endpackage

// File: rtl/kvosic_prescaler.sv
// Step-rate divider: tick whenever the count has reached the reload value.
module kvosic_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic [PRESC_W-1:0] reload,
  output logic               tick
);
  logic [PRESC_W-1:0] count;

  // >= rather than == so a reload lowered below the live count wraps immediately
  assign tick = (count >= reload);

  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/kvosic_counter_ctrl.sv
// Command sequencer driving the kvosic counter's step/direction/load controls.
module kvosic_counter_ctrl #(
  parameter int WIDTH         = 4,
  parameter int PRESC_W       = 4,
  parameter int PRESC_DEFAULT = kvosic_ctrl_pkg::PRESC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             busy,
  output logic             done
);
  import kvosic_ctrl_pkg::*;

  logic [2:0]         state;
  logic [PRESC_W-1:0] reload;
  logic [WIDTH-1:0]   target;
  logic               done_q;
  logic               tick;
  logic               accept;
  logic               match;
  logic               run_cmd;
  logic               running;

  assign cmd_ready = ena & rst_n & (state != ST_LOAD) & (state != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;
  assign match     = (cnt_value == target);
  assign running   = (state == ST_RUN) | (state == ST_RUN_TO);
  assign run_cmd   = accept & ((cmd_op == OP_RUN) | (cmd_op == OP_RUN_TO));
  assign busy      = (state != ST_IDLE);
  assign cnt_load  = ena & (state == ST_LOAD);
  assign done      = ena & done_q;

  always_comb begin
    cnt_en = 1'b0;
    if (ena) begin
      case (state)
        ST_RUN:    cnt_en = tick;
        ST_RUN_TO: cnt_en = tick & ~match;
        ST_STEP:   cnt_en = 1'b1;
        default:   cnt_en = 1'b0;
      endcase
    end
  end

  kvosic_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena & running),
    .clear  (run_cmd),
    .reload (reload),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      reload       <= PRESC_W'(PRESC_DEFAULT);
      target       <= '0;
      done_q       <= 1'b0;
      cnt_up       <= 1'b1;
      cnt_load_val <= '0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state)
        ST_LOAD, ST_STEP: state <= ST_IDLE;
        ST_RUN_TO: if (match) begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
        default: ;
      endcase
      // an accepted command overrides whatever the current state decided
      if (accept) begin
        case (cmd_op)
          OP_LOAD: begin
            state        <= ST_LOAD;
            cnt_load_val <= cmd_arg;
          end
          OP_RUN: begin
            state  <= ST_RUN;
            cnt_up <= cmd_arg[0];
          end
          OP_STOP:      state  <= ST_IDLE;
          OP_SET_PRESC: reload <= PRESC_W'(cmd_arg);
          OP_RUN_TO: begin
            state  <= ST_RUN_TO;
            target <= cmd_arg;
          end
          OP_STEP: begin
            state  <= ST_STEP;
            cnt_up <= cmd_arg[0];
          end
          default: ;
        endcase
      end
    end
  end
endmodule
